// File: rtl/cpu_pkg.sv
// Shared opcode, field-position and FSM state definitions for the fetch/decode/execute controller.
package cpu_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_LDI  = 3'b010;
    localparam logic [2:0] OP_MOV  = 3'b011;
    localparam logic [2:0] OP_JZ   = 3'b100;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam int unsigned OP_LSB  = 5;
    localparam int unsigned RD_BIT  = 4;
    localparam int unsigned RS_BIT  = 3;
    localparam int unsigned IMM_LSB = 0;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StWb,
        StHalt
    } state_e;

endpackage

// File: rtl/exec_unit.sv
// Combinational execute stage: computes the write-back result, ADD carry and next PC for one instruction.
module exec_unit
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W   = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic [2:0]        opcode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        imm4,
    input  logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic [PC_W-1:0]   next_pc,
    output logic              do_write,
    output logic              is_halt,
    output logic              is_illegal
);

    logic [DATA_W:0] w_sum;
    logic [PC_W-1:0] w_off;

    always_comb begin
        w_sum      = {1'b0, a} + {1'b0, b};
        w_off      = PC_W'($signed(imm4));
        result     = '0;
        carry      = 1'b0;
        next_pc    = pc + PC_W'(1);
        do_write   = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_NOP: ;
            OP_ADD: begin
                result   = w_sum[DATA_W-1:0];
                carry    = w_sum[DATA_W];
                do_write = 1'b1;
            end
            OP_LDI: begin
                result   = DATA_W'(imm4);
                do_write = 1'b1;
            end
            OP_MOV: begin
                result   = b;
                do_write = 1'b1;
            end
            OP_JZ: begin
                // PC arithmetic wraps naturally at PC_W bits
                if (a == '0) next_pc = pc + w_off;
            end
            OP_HALT: begin
                is_halt = 1'b1;
                next_pc = pc;
            end
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_decode_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback controller driving a two-entry register file.
module instr_decode_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W   = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic              readReg1_add,
    output logic              readReg2_add,
    input  logic [DATA_W-1:0] reg_data1,
    input  logic [DATA_W-1:0] reg_data2,
    output logic              writeReg1_add,
    output logic [DATA_W-1:0] writeData,
    output logic              writeEnable,
    output logic [PC_W-1:0]   pc,
    output logic              busy,
    output logic              halted,
    output logic              carry,
    output logic              illegal
);

    state_e            r_state;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   r_next_pc;
    logic [PC_W-1:0]   r_imem_addr;
    logic [DATA_W-1:0] r_ir;
    logic              r_rd_sel;
    logic              r_rs_sel;
    logic              r_wr_sel;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic              r_carry;
    logic              r_illegal;

    logic [2:0]        w_opcode;
    logic [DATA_W-1:0] w_result;
    logic              w_carry;
    logic [PC_W-1:0]   w_next_pc;
    logic              w_do_write;
    logic              w_is_halt;
    logic              w_is_illegal;

    assign w_opcode = r_ir[OP_LSB +: 3];

    exec_unit #(
        .PC_W   (PC_W),
        .DATA_W (DATA_W)
    ) u_exec (
        .opcode     (w_opcode),
        .a          (reg_data1),
        .b          (reg_data2),
        .imm4       (r_ir[IMM_LSB +: 4]),
        .pc         (r_pc),
        .result     (w_result),
        .carry      (w_carry),
        .next_pc    (w_next_pc),
        .do_write   (w_do_write),
        .is_halt    (w_is_halt),
        .is_illegal (w_is_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_pc        <= '0;
            r_next_pc   <= '0;
            r_imem_addr <= '0;
            r_ir        <= '0;
            r_rd_sel    <= 1'b0;
            r_rs_sel    <= 1'b0;
            r_wr_sel    <= 1'b0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_carry     <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_state     <= StFetch;
                        r_pc        <= '0;
                        r_imem_addr <= '0;
                    end
                end
                StFetch: r_state <= StDecode;
                StDecode: begin
                    // Memory data for the fetched address is valid this cycle
                    r_ir     <= imem_data;
                    r_rd_sel <= imem_data[RD_BIT];
                    r_rs_sel <= imem_data[RS_BIT];
                    r_state  <= StExec;
                end
                StExec: begin
                    if (w_is_halt) begin
                        r_state <= StHalt;
                    end else begin
                        r_state   <= StWb;
                        r_next_pc <= w_next_pc;
                        r_we      <= w_do_write;
                        r_wr_sel  <= r_ir[RD_BIT];
                        if (w_do_write) r_wdata <= w_result;
                        if (w_opcode == OP_ADD) r_carry <= w_carry;
                        if (w_is_illegal) r_illegal <= 1'b1;
                    end
                end
                StWb: begin
                    r_pc        <= r_next_pc;
                    r_imem_addr <= r_next_pc;
                    r_state     <= StFetch;
                end
                StHalt: r_state <= StHalt;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign imem_addr     = r_imem_addr;
    assign readReg1_add  = r_rd_sel;
    assign readReg2_add  = r_rs_sel;
    assign writeReg1_add = r_wr_sel;
    assign writeData     = r_wdata;
    assign writeEnable   = r_we;
    assign pc            = r_pc;
    assign busy          = (r_state == StFetch) || (r_state == StDecode) ||
                           (r_state == StExec)  || (r_state == StWb);
    assign halted        = (r_state == StHalt);
    assign carry         = r_carry;
    assign illegal       = r_illegal;

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Directed bench: models the instruction memory and register file, checks writes, PC and flags.
module tb_instr_decode_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] imem_addr;
    logic [7:0] imem_data;
    logic       readReg1_add;
    logic       readReg2_add;
    logic [7:0] reg_data1;
    logic [7:0] reg_data2;
    logic       writeReg1_add;
    logic [7:0] writeData;
    logic       writeEnable;
    logic [3:0] pc;
    logic       busy;
    logic       halted;
    logic       carry;
    logic       illegal;

    instr_decode_ctrl #(
        .PC_W   (4),
        .DATA_W (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .readReg1_add  (readReg1_add),
        .readReg2_add  (readReg2_add),
        .reg_data1     (reg_data1),
        .reg_data2     (reg_data2),
        .writeReg1_add (writeReg1_add),
        .writeData     (writeData),
        .writeEnable   (writeEnable),
        .pc            (pc),
        .busy          (busy),
        .halted        (halted),
        .carry         (carry),
        .illegal       (illegal)
    );

    always #5 clk = ~clk;

    logic [7:0] imem [16];
    logic [7:0] rf [2];
    logic [7:0] rf_init0 = 8'h00;
    logic [7:0] rf_init1 = 8'h00;
    logic       rf_load = 1'b0;

    // Synchronous instruction memory and register file with combinational read
    always @(posedge clk) begin
        imem_data <= imem[imem_addr];
        if (rf_load) begin
            rf[0] <= rf_init0;
            rf[1] <= rf_init1;
        end else if (writeEnable) begin
            rf[writeReg1_add] <= writeData;
        end
    end
    assign reg_data1 = rf[readReg1_add];
    assign reg_data2 = rf[readReg2_add];

    int edge_cnt = 0;
    int e0 = 0;
    int we_cyc_q[$];
    logic [7:0] wd_q[$];
    logic wa_q[$];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) begin
        if (writeEnable) begin
            we_cyc_q.push_back(edge_cnt - e0);
            wd_q.push_back(writeData);
            wa_q.push_back(writeReg1_add);
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 16; i++) imem[i] = 8'hE0;
    endtask

    task automatic apply_reset(input logic [7:0] s0, input logic [7:0] s1);
        @(negedge clk);
        rf_init0 = s0;
        rf_init1 = s1;
        rf_load  = 1'b1;
        rst      = 1'b1;
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        rf_load = 1'b0;
    endtask

    // Returns at the negedge of cycle 1 (first FETCH cycle)
    task automatic pulse_start();
        we_cyc_q.delete();
        wd_q.delete();
        wa_q.delete();
        e0    = edge_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (!halted && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, halted}, 32'd1);
    endtask

    initial begin
        // ADD s0,s1 then HALT
        clear_imem();
        imem[0] = 8'h28;
        imem[1] = 8'hE0;
        apply_reset(8'd4, 8'd3);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_we", {31'd0, writeEnable}, 32'd0);
        check("rst_pc", {28'd0, pc}, 32'd0);
        check("rst_imem_addr", {28'd0, imem_addr}, 32'd0);
        check("rst_wdata", {24'd0, writeData}, 32'd0);
        check("rst_carry", {31'd0, carry}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_rd_sel", {30'd0, readReg1_add, readReg2_add}, 32'd0);
        check("rst_wr_sel", {31'd0, writeReg1_add}, 32'd0);
        pulse_start();
        check("add_busy", {31'd0, busy}, 32'd1);
        wait_halt("add_halt");
        check("add_we_cnt", we_cyc_q.size(), 32'd1);
        check("add_we_cyc", we_cyc_q[0], 32'd4);
        check("add_wa", {31'd0, wa_q[0]}, 32'd0);
        check("add_wd", {24'd0, wd_q[0]}, 32'h07);
        check("add_carry", {31'd0, carry}, 32'd0);
        check("add_pc", {28'd0, pc}, 32'd1);
        check("add_busy_halt", {31'd0, busy}, 32'd0);

        // LDI s1,15 ; MOV s0,s1 ; HALT
        clear_imem();
        imem[0] = 8'h5F;
        imem[1] = 8'h68;
        apply_reset(8'd0, 8'd0);
        pulse_start();
        wait_halt("ldi_halt");
        check("ldi_we_cnt", we_cyc_q.size(), 32'd2);
        check("ldi_wd", {24'd0, wd_q[0]}, 32'h0F);
        check("ldi_wa", {31'd0, wa_q[0]}, 32'd1);
        check("mov_wd", {24'd0, wd_q[1]}, 32'h0F);
        check("mov_wa", {31'd0, wa_q[1]}, 32'd0);
        check("mov_we_cyc", we_cyc_q[1], 32'd8);
        check("mov_pc", {28'd0, pc}, 32'd2);

        // ADD overflow
        clear_imem();
        imem[0] = 8'h28;
        apply_reset(8'hFF, 8'h01);
        pulse_start();
        wait_halt("ovf_halt");
        check("ovf_wd", {24'd0, wd_q[0]}, 32'h00);
        check("ovf_carry", {31'd0, carry}, 32'd1);

        // JZ taken backwards: 0 -> 2 -> 3 -> 1 (HALT)
        clear_imem();
        imem[0] = 8'h82;
        imem[2] = 8'h00;
        imem[3] = 8'h8E;
        apply_reset(8'd0, 8'd5);
        pulse_start();
        wait_halt("jz_halt");
        check("jz_we_cnt", we_cyc_q.size(), 32'd0);
        check("jz_pc", {28'd0, pc}, 32'd1);

        // JZ not taken
        clear_imem();
        for (int i = 0; i < 3; i++) imem[i] = 8'h00;
        imem[3] = 8'h8E;
        apply_reset(8'd5, 8'd0);
        pulse_start();
        wait_halt("jzn_halt");
        check("jzn_pc", {28'd0, pc}, 32'd4);

        // PC wrap both ways: 0 -(-2)-> 14 (LDI s0,1) -> 15 -(+1)-> 0 -> 1 (HALT)
        clear_imem();
        imem[0]  = 8'h8E;
        imem[14] = 8'h41;
        imem[15] = 8'h91;
        apply_reset(8'd0, 8'd0);
        pulse_start();
        wait_halt("wrap_halt");
        check("wrap_we_cnt", we_cyc_q.size(), 32'd1);
        check("wrap_we_cyc", we_cyc_q[0], 32'd8);
        check("wrap_pc", {28'd0, pc}, 32'd1);

        // Illegal opcode, then LDI; start pulsed while busy must be ignored
        clear_imem();
        imem[0] = 8'hA0;
        imem[1] = 8'h5F;
        apply_reset(8'd0, 8'd0);
        pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_halt("ill_halt");
        check("ill_flag", {31'd0, illegal}, 32'd1);
        check("ill_we_cnt", we_cyc_q.size(), 32'd1);
        check("ill_we_cyc", we_cyc_q[0], 32'd8);
        check("ill_pc", {28'd0, pc}, 32'd2);

        // Reset during EXECUTE of ADD aborts; restart runs from imem[0]
        clear_imem();
        imem[0] = 8'h28;
        apply_reset(8'd4, 8'd3);
        pulse_start();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_pc", {28'd0, pc}, 32'd0);
        check("abort_we", {31'd0, writeEnable}, 32'd0);
        repeat (6) @(negedge clk);
        check("abort_we_cnt", we_cyc_q.size(), 32'd0);
        check("abort_idle", {31'd0, busy}, 32'd0);
        pulse_start();
        wait_halt("restart_halt");
        check("restart_we_cnt", we_cyc_q.size(), 32'd1);
        check("restart_wd", {24'd0, wd_q[0]}, 32'h07);
        check("restart_pc", {28'd0, pc}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_decode_ctrl.md
Name: instr_decode_ctrl

Overview:
- Multi-cycle fetch/decode/execute controller that sits directly upstream of the two-entry (s0/s1) 8-bit register file.
- Fetches 8-bit instructions from a synchronous instruction memory and decodes them.
- Drives the register file's read addresses, reads s0/s1 operands back, computes ADD/LDI/MOV/JZ results.
- Issues the register-file write (writeReg1_add / writeData / writeEnable) and sequences the PC.

Parameters:
- PC_W, 4, PC and instruction-memory address width (16 instructions).
- DATA_W, 8, datapath and instruction width.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  begin execution at PC 0 (honoured in IDLE only)
- imem_addr  out  PC_W  instruction address; memory returns data one cycle later
- imem_data  in  DATA_W  instruction word from synchronous memory
- readReg1_add  out  1  src1/dest register select (instr bit 4)
- readReg2_add  out  1  src2 register select (instr bit 3)
- reg_data1  in  DATA_W  register file read data for readReg1_add
- reg_data2  in  DATA_W  register file read data for readReg2_add
- writeReg1_add  out  1  destination register select
- writeData  out  DATA_W  result to write
- writeEnable  out  1  one-cycle write strobe
- pc  out  PC_W  current PC
- busy  out  1  high in FETCH/DECODE/EXECUTE/WRITEBACK
- halted  out  1  high in HALT
- carry  out  1  carry-out of the last ADD
- illegal  out  1  sticky: an undefined opcode was executed

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - State IDLE.
  - pc, imem_addr, writeData and the IR all 0.
  - writeEnable, read/write address outputs, busy, halted, carry and illegal all 0.
- Reset mid-instruction aborts it. No writeEnable is asserted in the cycle after the reset edge.
- Encoding:
  - op = [7:5], rd = [4], rs = [3], imm4/off4 = [3:0].
  - 000 NOP.
  - 001 ADD: rd = rd + rs.
  - 010 LDI: rd = zero-extended imm4.
  - 011 MOV: rd = rs.
  - 100 JZ: if rd == 0 then pc = pc + sext(off4), else pc + 1.
  - 111 HALT.
  - 101/110 illegal: set illegal, otherwise behave as NOP.
- FSM: IDLE -> FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH. HALT is terminal until rst.
  - IDLE: start=1 -> FETCH. start is ignored in every other state.
  - FETCH: imem_addr = pc.
  - DECODE: latch IR from imem_data. Drive readReg1_add = IR[4] and readReg2_add = IR[3]; hold them through WRITEBACK.
  - EXECUTE: sample reg_data1/reg_data2 at the closing edge. Compute result and next pc.
    - ADD: result = (a + b) mod 256; carry = bit 8 of the sum. carry is updated only by ADD.
    - HALT opcode -> HALT state; pc is not advanced.
  - WRITEBACK:
    - ADD/LDI/MOV only: writeEnable = 1 for exactly one cycle, with writeReg1_add = IR[4] and writeData = result stable in the same cycle.
    - pc updates at the closing edge.
- Latency: 4 cycles per instruction, start edge to first writeEnable = 4 cycles.
- PC arithmetic is modulo 2^PC_W: 15 + 1 wraps to 0, and 0 + (-2) gives 14.
- JZ tests reg_data1 (rd), not a flag.
- Outputs:
  - busy = 1 in the four execution states.
  - halted = 1 only in HALT.
  - illegal is cleared only by rst.

Decomposition:
- Shared package cpu_pkg:
  - Opcode localparams OP_NOP..OP_HALT.
  - Field bit positions (RD_BIT = 4, RS_BIT = 3, IMM_LSB = 0).
  - The FSM state enum.
- One natural sub-module: exec_unit, combinational. Inputs: opcode, a, b, imm4, pc. Outputs: result, carry, next_pc, do_write, is_halt, is_illegal.
- The FSM and registers stay in instr_decode_ctrl.

Test Plan:
- RF s0=4, s1=3; imem[0]=0x28 (ADD s0,s1), imem[1]=0xE0; pulse start -> writeEnable exactly one cycle at cycle 4 with writeReg1_add=0, writeData=0x07, carry=0; then halted=1, pc=1.
- imem[0]=0x5F (LDI s1,15) -> writeData=0x0F, writeReg1_add=1; imem[1]=0x68 (MOV s0,s1) -> writeData=0x0F, writeReg1_add=0.
- s0=0xFF, s1=0x01, ADD 0x28 -> writeData=0x00, carry=1.
- s0=0 at pc=3, instr 0x8E (JZ s0,-2) -> next pc=1, no writeEnable. With s0≠0 -> pc=4. JZ +1 at pc=15 -> pc=0 (wrap).
- instr 0xA0 -> illegal=1 and stays 1, no writeEnable, pc advances; start pulsed while busy has no effect.
- rst asserted in EXECUTE of an ADD -> next cycle IDLE, pc=0, writeEnable never pulses; restart executes from imem[0].
